fb_fill_ctrl: RTL and testbench

Write-side controller for the 320×240, 12-bit VGA framebuffer. It merges single-pixel CPU writes with a hardware rectangle-fill engine into the single write port of the display block (`we_i`/`addr_i`/`wdata_i`). CPU writes always have priority, and the fill engine stalls on any conflict. It sits between the bus-side peripheral registers and the VGA display module, in the same `clk` domain.

---
 rtl/fb_pkg.sv | 29 ++
 rtl/fb_addr_gen.sv | 61 ++++++
 rtl/fb_fill_ctrl.sv | 151 +++++++++++++++
 tb/tb_fb_fill_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared constants, FSM state type and the constant-stride row-base helper for the framebuffer write side.
package fb_pkg;

    localparam int FB_W       = 320;
    localparam int FB_H       = 240;
    localparam int FB_PIXELS  = 76800;
    localparam int FB_ADDR_W  = 17;
    localparam int FB_COLOR_W = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } fill_state_t;

    // y*stride as a sum of shifted copies of y; for 320 this is (y<<8)+(y<<6).
    function automatic logic [FB_ADDR_W-1:0] row_base_of(input logic [7:0] y, input int stride);
        logic [FB_ADDR_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < FB_ADDR_W; i++) begin
            if (stride[i]) begin
                acc = acc + (FB_ADDR_W'(y) << i);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Incremental rectangle address generator: column/row counters plus a row-base accumulator,
// driven by load (start of rectangle) and step (one pixel consumed) with a last-pixel flag.
module fb_addr_gen #(
    parameter int STRIDE = 320
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_step,
    input  logic [8:0]  i_x0,
    input  logic [16:0] i_row_base,
    input  logic [8:0]  i_cw,
    input  logic [7:0]  i_ch,
    output logic [16:0] o_addr,
    output logic        o_last
);
    import fb_pkg::*;

    logic [8:0]           r_col;
    logic [7:0]           r_row;
    logic [FB_ADDR_W-1:0] r_row_base;
    logic [8:0]           r_x0;
    logic [8:0]           r_cw;
    logic [7:0]           r_ch;

    logic w_col_last;
    logic w_row_last;

    assign w_col_last = (r_col == r_cw - 9'd1);
    assign w_row_last = (r_row == r_ch - 8'd1);
    assign o_last     = w_col_last && w_row_last;
    assign o_addr     = r_row_base + FB_ADDR_W'(r_x0) + FB_ADDR_W'(r_col);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col      <= '0;
            r_row      <= '0;
            r_row_base <= '0;
            r_x0       <= '0;
            r_cw       <= '0;
            r_ch       <= '0;
        end else if (i_load) begin
            r_col      <= '0;
            r_row      <= '0;
            r_row_base <= i_row_base;
            r_x0       <= i_x0;
            r_cw       <= i_cw;
            r_ch       <= i_ch;
        end else if (i_step) begin
            if (w_col_last) begin
                // Wrap to the next row; the base wraps modulo 2^17 like every address.
                r_col      <= '0;
                r_row      <= r_row + 8'd1;
                r_row_base <= r_row_base + FB_ADDR_W'(STRIDE);
            end else begin
                r_col      <= r_col + 9'd1;
            end
        end
    end

endmodule

// File: rtl/fb_fill_ctrl.sv
// Framebuffer write-port controller: CPU pixel writes (always first) merged with a rectangle fill engine.
// Optional clipping to the visible area is enabled by defining FB_FILL_CLIP_EN.
module fb_fill_ctrl #(
    parameter int FB_W = 320,
    parameter int FB_H = 240
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_we_i,
    input  logic [16:0] cpu_addr_i,
    input  logic [11:0] cpu_wdata_i,
    input  logic        fill_start_i,
    input  logic [8:0]  fill_x0_i,
    input  logic [7:0]  fill_y0_i,
    input  logic [8:0]  fill_w_i,
    input  logic [7:0]  fill_h_i,
    input  logic [11:0] fill_color_i,
    output logic        fill_busy_o,
    output logic        fill_done_o,
    output logic        we_o,
    output logic [16:0] addr_o,
    output logic [11:0] wdata_o
);
    import fb_pkg::*;

    fill_state_t r_state;
    fill_state_t w_state_next;

    logic [8:0]            r_x0;
    logic [7:0]            r_y0;
    logic [8:0]            r_w;
    logic [7:0]            r_h;
    logic [FB_COLOR_W-1:0] r_color;

    logic [8:0]           w_cw;
    logic [7:0]           w_ch;
    logic [FB_ADDR_W-1:0] w_row_base;
    logic                 w_load;
    logic                 w_step;
    logic                 w_accept;
    logic [FB_ADDR_W-1:0] w_gen_addr;
    logic                 w_gen_last;

    logic                  r_we;
    logic [FB_ADDR_W-1:0]  r_addr;
    logic [FB_COLOR_W-1:0] r_wdata;
    logic                  r_busy;
    logic                  r_done;

`ifdef FB_FILL_CLIP_EN
    logic [8:0] w_x_room;
    logic [7:0] w_y_room;
    logic       w_offscreen;

    assign w_offscreen = (int'(r_x0) >= FB_W) || (int'(r_y0) >= FB_H);
    assign w_x_room    = w_offscreen ? 9'd0 : 9'(FB_W - int'(r_x0));
    assign w_y_room    = w_offscreen ? 8'd0 : 8'(FB_H - int'(r_y0));
    assign w_cw        = (r_w < w_x_room) ? r_w : w_x_room;
    assign w_ch        = (r_h < w_y_room) ? r_h : w_y_room;
`else
    assign w_cw = r_w;
    assign w_ch = r_h;
`endif

    assign w_row_base = row_base_of(r_y0, FB_W);
    assign w_accept   = (r_state == IDLE) && fill_start_i;
    assign w_load     = (r_state == SETUP);
    // A CPU write in the same cycle holds the scheduled fill pixel in place.
    assign w_step     = (r_state == FILL) && !cpu_we_i;

    fb_addr_gen #(
        .STRIDE(FB_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_x0       (r_x0),
        .i_row_base (w_row_base),
        .i_cw       (w_cw),
        .i_ch       (w_ch),
        .o_addr     (w_gen_addr),
        .o_last     (w_gen_last)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:  if (fill_start_i) w_state_next = SETUP;
            SETUP: w_state_next = ((w_cw == 9'd0) || (w_ch == 8'd0)) ? DONE : FILL;
            FILL:  if (w_step && w_gen_last) w_state_next = DONE;
            DONE:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == SETUP) || (w_state_next == FILL);
            r_done  <= (w_state_next == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x0    <= '0;
            r_y0    <= '0;
            r_w     <= '0;
            r_h     <= '0;
            r_color <= '0;
        end else if (w_accept) begin
            r_x0    <= fill_x0_i;
            r_y0    <= fill_y0_i;
            r_w     <= fill_w_i;
            r_h     <= fill_h_i;
            r_color <= fill_color_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (cpu_we_i) begin
            r_we    <= 1'b1;
            r_addr  <= cpu_addr_i;
            r_wdata <= cpu_wdata_i;
        end else if (w_step) begin
            r_we    <= 1'b1;
            r_addr  <= w_gen_addr;
            r_wdata <= r_color;
        end else begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end
    end

    assign we_o        = r_we;
    assign addr_o      = r_addr;
    assign wdata_o     = r_wdata;
    assign fill_busy_o = r_busy;
    assign fill_done_o = r_done;

endmodule

// File: tb/tb_fb_fill_ctrl.sv
// Directed and randomized checks of fb_fill_ctrl against a pixel-queue reference model.
module tb_fb_fill_ctrl;

    localparam int W = 320;
    localparam int H = 240;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_we_i;
    logic [16:0] cpu_addr_i;
    logic [11:0] cpu_wdata_i;
    logic        fill_start_i;
    logic [8:0]  fill_x0_i;
    logic [7:0]  fill_y0_i;
    logic [8:0]  fill_w_i;
    logic [7:0]  fill_h_i;
    logic [11:0] fill_color_i;
    logic        fill_busy_o;
    logic        fill_done_o;
    logic        we_o;
    logic [16:0] addr_o;
    logic [11:0] wdata_o;

    fb_fill_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_we_i     (cpu_we_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_wdata_i  (cpu_wdata_i),
        .fill_start_i (fill_start_i),
        .fill_x0_i    (fill_x0_i),
        .fill_y0_i    (fill_y0_i),
        .fill_w_i     (fill_w_i),
        .fill_h_i     (fill_h_i),
        .fill_color_i (fill_color_i),
        .fill_busy_o  (fill_busy_o),
        .fill_done_o  (fill_done_o),
        .we_o         (we_o),
        .addr_o       (addr_o),
        .wdata_o      (wdata_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int done_cyc = -1;
    int obs_addr[$];

    // Reference model: a command becomes a queue of pixel addresses; one is consumed per CPU-free cycle.
    bit   m_active = 0;
    bit   m_setup  = 0;
    bit   m_done   = 0;
    int   m_q[$];
    int   m_color  = 0;
    logic e_we, e_busy, e_done;
    logic [16:0] e_addr;
    logic [11:0] e_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic build_queue(input int x0, input int y0, input int w, input int h);
        int cw, ch;
        cw = w;
        ch = h;
`ifdef FB_FILL_CLIP_EN
        if (x0 >= W || y0 >= H) begin
            cw = 0;
            ch = 0;
        end else begin
            if (W - x0 < cw) cw = W - x0;
            if (H - y0 < ch) ch = H - y0;
        end
`endif
        m_q.delete();
        for (int r = 0; r < ch; r++)
            for (int c = 0; c < cw; c++)
                m_q.push_back((y0 * W + r * W + x0 + c) % 131072);
    endtask

    task automatic model_update(input bit we, input int a, input int d, input bit st,
                                input int x0, input int y0, input int w, input int h,
                                input int col, input bit rs);
        bit nact, nset, ndone;
        if (rs) begin
            m_active = 0; m_setup = 0; m_done = 0; m_q.delete();
            e_we = 0; e_addr = 0; e_data = 0; e_busy = 0; e_done = 0;
            return;
        end
        nact = m_active; nset = 0; ndone = 0;
        e_we = we; e_addr = we ? 17'(a) : 17'd0; e_data = we ? 12'(d) : 12'd0;
        if (m_active && m_setup) begin
            if (m_q.size() == 0) begin nact = 0; ndone = 1; end
        end else if (m_active) begin
            if (!we) begin
                e_we = 1; e_addr = 17'(m_q.pop_front()); e_data = 12'(m_color);
                if (m_q.size() == 0) begin nact = 0; ndone = 1; end
            end
        end else if (!m_done && st) begin
            nact = 1; nset = 1; m_color = col;
            build_queue(x0, y0, w, h);
        end
        m_active = nact; m_setup = nset; m_done = ndone;
        e_busy = nact; e_done = ndone;
    endtask

    task automatic step(input bit we, input int a, input int d, input bit st,
                        input int x0, input int y0, input int w, input int h,
                        input int col, input bit rs);
        rst = rs; cpu_we_i = we; cpu_addr_i = 17'(a); cpu_wdata_i = 12'(d);
        fill_start_i = st; fill_x0_i = 9'(x0); fill_y0_i = 8'(y0);
        fill_w_i = 9'(w); fill_h_i = 8'(h); fill_color_i = 12'(col);
        @(posedge clk);
        cyc++;
        model_update(we, a % 131072, d % 4096, st, x0 % 512, y0 % 256, w % 512, h % 256, col % 4096, rs);
        #1;
        check("we", 32'(we_o), 32'(e_we));
        check("busy", 32'(fill_busy_o), 32'(e_busy));
        check("done", 32'(fill_done_o), 32'(e_done));
        if (e_we || rs) begin
            check("addr", 32'(addr_o), 32'(e_addr));
            check("wdata", 32'(wdata_o), 32'(e_data));
        end
        if (we_o) obs_addr.push_back(int'(addr_o));
        if (fill_done_o) done_cyc = cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cpu(input int a, input int d);
        step(1, a, d, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic start(input int x0, input int y0, input int w, input int h, input int col);
        step(0, 0, 0, 1, x0, y0, w, h, col, 0);
    endtask

    initial begin
        int cs, prev_done;

        // Reset state
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 77, 5, 1, 3, 3, 3, 3, 7, 1);

        // Single CPU write
        cpu(1234, 12'h0F0);
        idle(2);

        // 2x2 fill
        obs_addr.delete();
        cs = cyc;
        start(10, 5, 2, 2, 12'hF00);
        idle(8);
        check("fill2x2_n", obs_addr.size(), 4);
        if (obs_addr.size() == 4) begin
            check("fill2x2_a0", obs_addr[0], 1610);
            check("fill2x2_a1", obs_addr[1], 1611);
            check("fill2x2_a2", obs_addr[2], 1930);
            check("fill2x2_a3", obs_addr[3], 1931);
        end
        check("fill2x2_done_cyc", done_cyc - cs, 6);

        // Contention: CPU writes in cycles 3 and 4
        obs_addr.delete();
        cs = cyc;
        start(10, 5, 2, 2, 12'hF00);
        idle(2);
        cpu(500, 12'h123);
        cpu(501, 12'h456);
        idle(6);
        check("cont_n", obs_addr.size(), 6);
        if (obs_addr.size() == 6) begin
            check("cont_a0", obs_addr[0], 1610);
            check("cont_a1", obs_addr[1], 500);
            check("cont_a2", obs_addr[2], 501);
            check("cont_a3", obs_addr[3], 1611);
            check("cont_a5", obs_addr[5], 1931);
        end
        check("cont_done_cyc", done_cyc - cs, 8);

        // Clip at bottom-right corner
        obs_addr.delete();
        start(318, 239, 5, 3, 12'hABC);
        idle(22);
`ifdef FB_FILL_CLIP_EN
        check("clip_n", obs_addr.size(), 2);
`else
        check("clip_n", obs_addr.size(), 15);
`endif
        if (obs_addr.size() >= 2) begin
            check("clip_a0", obs_addr[0], 76798);
            check("clip_a1", obs_addr[1], 76799);
        end

        // Zero-size command
        obs_addr.delete();
        cs = cyc;
        start(4, 4, 0, 4, 12'h111);
        idle(3);
        check("zero_n", obs_addr.size(), 0);
        check("zero_done_cyc", done_cyc - cs, 2);

        // Start while busy is ignored
        obs_addr.delete();
        start(20, 10, 3, 2, 12'h0AA);
        idle(1);
        start(0, 0, 5, 5, 12'h555);
        idle(10);
        check("ign_n", obs_addr.size(), 6);
        if (obs_addr.size() == 6) check("ign_a0", obs_addr[0], 3220);

        // Reset in the middle of a 10x10 fill
        start(0, 0, 10, 10, 12'hFFF);
        idle(5);
        prev_done = done_cyc;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(3);
        check("rst_no_done", done_cyc, prev_done);
        start(1, 1, 1, 1, 12'h321);
        idle(4);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bit rw, rs, st;
            int w, h;
            rw = ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 7) == 0);
            rs = ($urandom_range(0, 299) == 0);
            w  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
            h  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 8));
            step(rw, int'($urandom_range(0, 131071)), int'($urandom_range(0, 4095)), st,
                 int'($urandom_range(0, 511)), int'($urandom_range(0, 255)), w, h,
                 int'($urandom_range(0, 4095)), rs);
        end
        idle(120);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
